// File: rtl/dma_mc_csr.sv
// Multi-channel DMA register file with a round-robin beat sequencer and an aggregate irq.
// Latency: register writes are visible next cycle, rdata and irq are registered, beat_* is combinational from state.
// Backpressure: beat_ready low holds the granted beat, XFER and the rr pointer.
module dma_mc_csr #(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h400,
    parameter logic [31:0] CH_STRIDE = 32'h20,
    parameter int          CNT_W     = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wr_en,
    input  logic                                        rd_en,
    input  logic [31:0]                                 addr,
    input  logic [31:0]                                 wdata,
    output logic [31:0]                                 rdata,
    output logic                                        beat_valid,
    input  logic                                        beat_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] beat_ch,
    output logic [31:0]                                 beat_src,
    output logic [31:0]                                 beat_dst,
    output logic                                        irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } ch_state_e;

    typedef struct packed {
        ch_state_e        st;
        logic             done;
        logic             error;
        logic             irq_en;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] xfer;
        logic [31:0]      src;
        logic [31:0]      dst;
    } ch_regs_t;

    ch_regs_t ch_q [NUM_CH];
    ch_regs_t ch_d [NUM_CH];

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic              grant_found;
    logic              beat_acc;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] irq_status;
    logic [NUM_CH-1:0] ch_start;
    logic [NUM_CH-1:0] ch_abort;
    logic [NUM_CH-1:0] ch_acc;
    logic [NUM_CH-1:0] hit_ctrl;
    logic [NUM_CH-1:0] hit_count;
    logic [NUM_CH-1:0] hit_src;
    logic [NUM_CH-1:0] hit_dst;
    logic [NUM_CH-1:0] hit_status;
    logic [NUM_CH-1:0] hit_xfer;
    logic              hit_glb;
    logic [31:0]       rd_mux;

    function automatic logic [31:0] win(input int c);
        return BASE_ADDR + CH_STRIDE * 32'(c);
    endfunction

    function automatic logic [CH_W-1:0] wrap_idx(input int v);
        return (v >= NUM_CH) ? CH_W'(v - NUM_CH) : CH_W'(v);
    endfunction

    // Address decode and per-channel command strobes
    always_comb begin
        hit_ctrl   = '0;
        hit_count  = '0;
        hit_src    = '0;
        hit_dst    = '0;
        hit_status = '0;
        hit_xfer   = '0;
        ch_start   = '0;
        ch_abort   = '0;
        busy       = '0;
        irq_status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit_ctrl[c]   = (addr == win(c));
            hit_count[c]  = (addr == win(c) + 32'h04);
            hit_src[c]    = (addr == win(c) + 32'h08);
            hit_dst[c]    = (addr == win(c) + 32'h0C);
            hit_status[c] = (addr == win(c) + 32'h10);
            hit_xfer[c]   = (addr == win(c) + 32'h14);
            // abort in the same write suppresses start
            ch_start[c]   = wr_en & hit_ctrl[c] & wdata[0] & ~wdata[1];
            ch_abort[c]   = wr_en & hit_ctrl[c] & wdata[1];
            busy[c]       = (ch_q[c].st == ST_BUSY);
            irq_status[c] = ch_q[c].irq_en & (ch_q[c].done | ch_q[c].error);
        end
        hit_glb = (addr == BASE_ADDR + CH_STRIDE * 32'(NUM_CH));
    end

    // First busy channel at or after rr_ptr, cyclically
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && busy[wrap_idx(int'(rr_ptr) + i)]) begin
                grant       = wrap_idx(int'(rr_ptr) + i);
                grant_found = 1'b1;
            end
        end
    end

    assign beat_valid = |busy;
    assign beat_acc   = beat_valid & beat_ready;
    assign beat_ch    = grant;
    assign beat_src   = beat_valid ? ch_q[grant].src + (32'(ch_q[grant].xfer) << 2) : '0;
    assign beat_dst   = beat_valid ? ch_q[grant].dst + (32'(ch_q[grant].xfer) << 2) : '0;

    always_comb begin
        ch_acc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_acc[c] = beat_acc & (grant == CH_W'(c));
        end
    end

    // Channel next state: software writes first, hardware sets override W1C
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_d[c] = ch_q[c];
            if (wr_en) begin
                if (hit_ctrl[c])  ch_d[c].irq_en = wdata[2];
                if (hit_count[c]) ch_d[c].count  = wdata[CNT_W-1:0];
                if (hit_src[c])   ch_d[c].src    = wdata;
                if (hit_dst[c])   ch_d[c].dst    = wdata;
                if (hit_status[c]) begin
                    if (wdata[1]) ch_d[c].done  = 1'b0;
                    if (wdata[2]) ch_d[c].error = 1'b0;
                end
            end
            case (ch_q[c].st)
                ST_BUSY: begin
                    if (ch_acc[c]) ch_d[c].xfer = ch_q[c].xfer + CNT_W'(1);
                    if (ch_abort[c]) begin
                        ch_d[c].st    = ST_ERR;
                        ch_d[c].error = 1'b1;
                    end else if (ch_acc[c] && (ch_q[c].xfer + CNT_W'(1) == ch_q[c].count)) begin
                        ch_d[c].st   = ST_DONE;
                        ch_d[c].done = 1'b1;
                    end
                end
                default: begin
                    if (ch_start[c]) begin
                        if (ch_q[c].count == '0) begin
                            ch_d[c].st    = ST_ERR;
                            ch_d[c].error = 1'b1;
                        end else begin
                            ch_d[c].st    = ST_BUSY;
                            ch_d[c].xfer  = '0;
                            ch_d[c].done  = 1'b0;
                            ch_d[c].error = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Read mux over the pre-write state, so read-during-write returns the old value
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_ctrl[c])   rd_mux = {29'b0, ch_q[c].irq_en, 2'b00};
            if (hit_count[c])  rd_mux = 32'(ch_q[c].count);
            if (hit_src[c])    rd_mux = ch_q[c].src;
            if (hit_dst[c])    rd_mux = ch_q[c].dst;
            if (hit_status[c]) rd_mux = {26'b0, ch_q[c].st, 1'b0, ch_q[c].error,
                                         ch_q[c].done, busy[c]};
            if (hit_xfer[c])   rd_mux = 32'(ch_q[c].xfer);
        end
        if (hit_glb) rd_mux = 32'(irq_status);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= ch_d[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rdata  <= '0;
            irq    <= 1'b0;
        end else begin
            if (beat_acc) rr_ptr <= wrap_idx(int'(grant) + 1);
            if (rd_en)    rdata  <= rd_mux;
            irq <= |irq_status;
        end
    end

endmodule

// File: tb/tb_dma_mc_csr.sv
// Bench for dma_mc_csr: register table, directed multi-cycle sequences, then random traffic
// checked against a queue-free behavioural model of the channel rules.
module tb_dma_mc_csr;

    localparam logic [31:0] BASE = 32'h400;
    localparam logic [31:0] STR  = 32'h20;
    localparam logic [31:0] GLB  = 32'h480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [1:0]  beat_ch;
    logic [31:0] beat_src;
    logic [31:0] beat_dst;
    logic        irq;

    dma_mc_csr #(.NUM_CH(4), .BASE_ADDR(BASE), .CH_STRIDE(STR), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_ch(beat_ch), .beat_src(beat_src), .beat_dst(beat_dst), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
        d = rdata;
    endtask

    function automatic logic [31:0] regaddr(input int c, input int off);
        return BASE + STR * c + off;
    endfunction

    // Behavioural model: state 0 idle, 1 busy, 2 done, 3 err
    int          m_cnt [4];
    int          m_xfer[4];
    int          m_st  [4];
    bit          m_ien [4];
    bit          m_done[4];
    bit          m_err [4];
    logic [31:0] m_src [4];
    logic [31:0] m_dst [4];
    int          m_ptr;

    function automatic int model_grant();
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (m_st[k] == 1) return k;
        end
        return -1;
    endfunction

    function automatic bit model_irq();
        bit r;
        r = 1'b0;
        for (int c = 0; c < 4; c++) r |= m_ien[c] & (m_done[c] | m_err[c]);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            if (a == regaddr(c, 0))    r = m_ien[c] ? 32'h4 : 32'h0;
            if (a == regaddr(c, 4))    r = m_cnt[c];
            if (a == regaddr(c, 8))    r = m_src[c];
            if (a == regaddr(c, 12))   r = m_dst[c];
            if (a == regaddr(c, 16))   r = m_st[c] * 16 + m_err[c] * 4 + m_done[c] * 2 + (m_st[c] == 1);
            if (a == regaddr(c, 20))   r = m_xfer[c];
        end
        if (a == GLB) begin
            for (int c = 0; c < 4; c++)
                if (m_ien[c] && (m_done[c] || m_err[c])) r[c] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_update(input bit w, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        int g;
        int oc[4];
        int ps[4];
        bit ab[4];
        bit sa[4];
        g = model_grant();
        for (int c = 0; c < 4; c++) begin
            oc[c] = m_cnt[c]; ps[c] = m_st[c]; ab[c] = 1'b0; sa[c] = 1'b0;
            if (w && a == regaddr(c, 0)) begin
                m_ien[c] = d[2]; ab[c] = d[1]; sa[c] = d[0] & ~d[1];
            end
            if (w && a == regaddr(c, 4))  m_cnt[c] = d & 32'hFFFF;
            if (w && a == regaddr(c, 8))  m_src[c] = d;
            if (w && a == regaddr(c, 12)) m_dst[c] = d;
            if (w && a == regaddr(c, 16)) begin
                if (d[1]) m_done[c] = 1'b0;
                if (d[2]) m_err[c]  = 1'b0;
            end
        end
        if (g >= 0 && rdy) begin
            m_xfer[g] = (m_xfer[g] + 1) & 32'hFFFF;
            m_ptr = (g + 1) % 4;
            if (m_xfer[g] == oc[g] && !ab[g]) begin m_st[g] = 2; m_done[g] = 1'b1; end
        end
        for (int c = 0; c < 4; c++) begin
            if (ab[c] && ps[c] == 1) begin
                m_st[c] = 3; m_err[c] = 1'b1;
            end else if (sa[c] && ps[c] != 1) begin
                if (oc[c] == 0) begin m_st[c] = 3; m_err[c] = 1'b1; end
                else begin m_xfer[c] = 0; m_done[c] = 1'b0; m_err[c] = 1'b0; m_st[c] = 1; end
            end
        end
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] v;
        int          seq[4];

        vt[0]  = '{1'b1, regaddr(1, 8),  32'h12345678, 32'h0, "w_src"};
        vt[1]  = '{1'b0, regaddr(1, 8),  32'h0, 32'h12345678, "rd_src"};
        vt[2]  = '{1'b1, regaddr(1, 4),  32'hFFFFFFFF, 32'h0, "w_count"};
        vt[3]  = '{1'b0, regaddr(1, 4),  32'h0, 32'h0000FFFF, "rd_count_width"};
        vt[4]  = '{1'b1, regaddr(1, 0),  32'hFFFFFFF4, 32'h0, "w_ctrl"};
        vt[5]  = '{1'b0, regaddr(1, 0),  32'h0, 32'h00000004, "rd_ctrl_ien"};
        vt[6]  = '{1'b1, regaddr(1, 16), 32'hFFFFFFFF, 32'h0, "w_status_ro"};
        vt[7]  = '{1'b0, regaddr(1, 16), 32'h0, 32'h0, "rd_status_idle"};
        vt[8]  = '{1'b1, regaddr(1, 20), 32'h0000ABCD, 32'h0, "w_xfer_ro"};
        vt[9]  = '{1'b0, regaddr(1, 20), 32'h0, 32'h0, "rd_xfer_ro"};
        vt[10] = '{1'b0, regaddr(1, 24), 32'h0, 32'h0, "rd_unmapped_18"};
        vt[11] = '{1'b1, regaddr(0, 28), 32'h5, 32'h0, "w_unmapped_1c"};
        vt[12] = '{1'b0, regaddr(0, 28), 32'h0, 32'h0, "rd_unmapped_1c"};
        vt[13] = '{1'b0, GLB,            32'h0, 32'h0, "rd_irq_status"};
        vt[14] = '{1'b1, regaddr(1, 0),  32'h0, 32'h0, "w_ctrl_clr"};
        vt[15] = '{1'b1, regaddr(1, 4),  32'h0, 32'h0, "w_count_clr"};

        // Reset state
        step(); step();
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_beat_valid", 32'(beat_valid), 0);
        chk("rst_beat_ch", 32'(beat_ch), 0);
        chk("rst_beat_src", beat_src, 0);
        chk("rst_beat_dst", beat_dst, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            if (vt[i].w) wr(vt[i].a, vt[i].d);
            else begin
                rd(vt[i].a, v);
                chk(vt[i].name, v, vt[i].exp);
            end
        end

        // Read-during-write returns the old value
        wr(regaddr(2, 8), 32'h55);
        wr_en = 1'b1; rd_en = 1'b1; addr = regaddr(2, 8); wdata = 32'hDEAD;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rdw_old", rdata, 32'h55);
        rd(regaddr(2, 8), v);
        chk("rdw_new", v, 32'hDEAD);

        // Single-channel transfer on ch0
        wr(regaddr(0, 8), 32'h1000);
        wr(regaddr(0, 12), 32'h2000);
        wr(regaddr(0, 4), 3);
        beat_ready = 1'b1;
        wr(regaddr(0, 0), 5);
        for (int i = 0; i < 3; i++) begin
            chk("t1_valid", 32'(beat_valid), 1);
            chk("t1_ch", 32'(beat_ch), 0);
            chk("t1_src", beat_src, 32'h1000 + 4 * i);
            chk("t1_dst", beat_dst, 32'h2000 + 4 * i);
            step();
        end
        chk("t1_valid_end", 32'(beat_valid), 0);
        chk("t1_irq_not_yet", 32'(irq), 0);
        rd(regaddr(0, 16), v);
        chk("t1_status", v, 32'h22);
        chk("t1_irq", 32'(irq), 1);
        rd(regaddr(0, 20), v);
        chk("t1_xfer", v, 3);
        wr(regaddr(0, 16), 32'h2);
        step();
        chk("t1_irq_clr", 32'(irq), 0);
        rd(regaddr(0, 16), v);
        chk("t1_status_clr", v, 32'h20);

        // Round-robin: pointer sits at 1 after ch0's last beat, so ch2 leads
        beat_ready = 1'b0;
        wr(regaddr(0, 4), 2);
        wr(regaddr(2, 4), 2);
        wr(regaddr(0, 0), 1);
        wr(regaddr(2, 0), 1);
        beat_ready = 1'b1;
        seq = '{2, 0, 2, 0};
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", 32'(beat_valid), 1);
            chk("t2_ch", 32'(beat_ch), seq[i]);
            step();
        end
        chk("t2_valid_end", 32'(beat_valid), 0);

        // Zero count
        wr(regaddr(1, 4), 0);
        wr(regaddr(1, 0), 1);
        chk("t3_zero_valid", 32'(beat_valid), 0);
        rd(regaddr(1, 16), v);
        chk("t3_zero_status", v, 32'h34);

        // Abort after two beats
        beat_ready = 1'b0;
        wr(regaddr(3, 4), 5);
        wr(regaddr(3, 0), 1);
        beat_ready = 1'b1;
        step(); step();
        beat_ready = 1'b0;
        wr(regaddr(3, 0), 2);
        chk("t3_abort_valid", 32'(beat_valid), 0);
        rd(regaddr(3, 16), v);
        chk("t3_abort_status", v, 32'h34);
        rd(regaddr(3, 20), v);
        chk("t3_abort_xfer", v, 2);

        // Backpressure and start-while-busy
        wr(regaddr(1, 4), 4);
        wr(regaddr(1, 8), 32'h100);
        wr(regaddr(1, 12), 32'h200);
        wr(regaddr(1, 0), 1);
        beat_ready = 1'b1;
        step();
        beat_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_valid", 32'(beat_valid), 1);
            chk("t4_hold_ch", 32'(beat_ch), 1);
            chk("t4_hold_src", beat_src, 32'h104);
            chk("t4_hold_dst", beat_dst, 32'h204);
            step();
        end
        wr(regaddr(1, 0), 1);
        rd(regaddr(1, 20), v);
        chk("t4_restart_ignored", v, 1);
        beat_ready = 1'b1;
        step(); step(); step();
        beat_ready = 1'b0;
        chk("t4_valid_end", 32'(beat_valid), 0);
        rd(regaddr(1, 16), v);
        chk("t4_status", v, 32'h22);
        rd(regaddr(1, 20), v);
        chk("t4_xfer", v, 4);

        // W1C racing the completing beat: the set wins
        wr(regaddr(0, 4), 1);
        wr(regaddr(0, 0), 1);
        beat_ready = 1'b1;
        wr(regaddr(0, 16), 32'h2);
        beat_ready = 1'b0;
        rd(regaddr(0, 16), v);
        chk("t5_race_status", v, 32'h22);

        // Reset mid-transfer
        wr(regaddr(2, 4), 10);
        wr(regaddr(2, 0), 5);
        beat_ready = 1'b1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(beat_valid), 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_src", beat_src, 0);
        step(); step();
        rst_n = 1'b1;
        beat_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 6; o++) begin
                rd(regaddr(c, 4 * o), v);
                chk("t5_rst_reg", v, 0);
            end
        end
        rd(GLB, v);
        chk("t5_rst_glb", v, 0);
        chk("t5_rst_irq", 32'(irq), 0);

        // Random traffic against the model, starting from the reset state
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_xfer[c] = 0; m_st[c] = 0; m_ien[c] = 0;
            m_done[c] = 0; m_err[c] = 0; m_src[c] = '0; m_dst[c] = '0;
        end
        m_ptr = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit          do_w;
            bit          do_r;
            bit          exp_irq;
            int          wc;
            int          wreg;
            int          g;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            beat_ready = ($urandom_range(0, 3) != 0);
            do_w = ($urandom_range(0, 2) == 0);
            do_r = ($urandom_range(0, 2) == 0);
            wc   = $urandom_range(0, 3);
            wreg = $urandom_range(0, 5) * 4;
            wd   = $urandom;
            if (wreg == 0) wd = $urandom_range(0, 7);
            if (wreg == 4) wd = (m_st[wc] == 1) ? m_xfer[wc] + $urandom_range(1, 3)
                                                : $urandom_range(0, 4);
            if (do_w) addr = regaddr(wc, wreg);
            else if ($urandom_range(0, 6) == 6) addr = GLB;
            else addr = regaddr($urandom_range(0, 3), $urandom_range(0, 7) * 4);
            wr_en = do_w; rd_en = do_r; wdata = wd;
            exp_rd  = model_read(addr);
            exp_irq = model_irq();
            g = model_grant();
            chk("rnd_valid", 32'(beat_valid), (g >= 0) ? 1 : 0);
            if (g >= 0) begin
                chk("rnd_ch", 32'(beat_ch), g);
                chk("rnd_src", beat_src, m_src[g] + 4 * m_xfer[g]);
                chk("rnd_dst", beat_dst, m_dst[g] + 4 * m_xfer[g]);
            end
            step();
            model_update(do_w, addr, wd, beat_ready);
            if (do_r) chk("rnd_rdata", rdata, exp_rd);
            chk("rnd_irq", 32'(irq), 32'(exp_irq));
            wr_en = 1'b0; rd_en = 1'b0;
        end
        beat_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 6; o++) begin
                rd(regaddr(c, 4 * o), v);
                chk("rnd_final_reg", v, model_read(regaddr(c, 4 * o)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
